// File: rtl/wb_xact_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_xact_pkg
//  Description : Shared FSM states and Wishbone cycle-type constants for the
//                burst transactor.
//  Revision    : 1.0
// ============================================================================
package wb_xact_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } xact_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [3:0] WB_SEL_ALL  = 4'hF;

endpackage
`default_nettype wire

// File: rtl/xact_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xact_sync_fifo
//  Description : Single-clock FIFO with occupancy count; buffers read data.
//  Revision    : 1.0
// ============================================================================
module xact_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_burst_xactor.sv
`default_nettype none
// ============================================================================
//  Module      : wb_burst_xactor
//  Description : Wishbone incrementing-burst master driven by a command and
//                write-data stream; read data returns through a FIFO.
//                Optional ack watchdog enabled by WB_XACT_TIMEOUT_EN.
//  Revision    : 1.0
// ============================================================================
module wb_burst_xactor
    import wb_xact_pkg::*;
#(
    parameter int DW       = 32,
    parameter int RD_DEPTH = 16
`ifdef WB_XACT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [29:0]   cmd_waddr,
    input  logic [7:0]    cmd_bl,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    input  logic          rdata_ready,
    output logic [DW-1:0] rdata,
    output logic          cmd_done,
    output logic          xact_err,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [31:0]   wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic [2:0]    wb_cti_o,
    input  logic          wb_ack_i,
    input  logic [DW-1:0] wb_dat_i
);

    localparam int CW = $clog2(RD_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RD_DEPTH);

    xact_state_e   state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [7:0]    beats_q, beats_d;
    logic          in_burst;
    logic          stb;
    logic          ack_hit;
    logic          abort;
    logic          fifo_push;
    logic [CW-1:0] fifo_count;

    assign in_burst = (state_q == BURST);
    // Read strobes only while a landing slot exists; the strobed word is pushed in its ack cycle.
    assign stb      = in_burst & (we_q ? wdata_valid : (fifo_count < FULL_CNT));
    assign ack_hit  = stb & wb_ack_i;

`ifdef WB_XACT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q;

    assign tmo_d    = (stb & ~wb_ack_i) ? tmo_q + TW'(1) : '0;
    assign abort    = stb & ~wb_ack_i & (tmo_q == TMO_LAST);
    assign xact_err = err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_q | abort;
        end
    end
`else
    assign abort    = 1'b0;
    assign xact_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = {cmd_waddr, 2'b00};
                    we_d    = cmd_we;
                    beats_d = cmd_bl;
                    state_d = (cmd_bl == 8'd0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (ack_hit) begin
                    addr_d  = addr_q + 32'd4;
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) state_d = DONE;
                end else if (abort) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so nothing is offered as accepted while reset is held.
    assign cmd_ready   = (state_q == IDLE) & ~wb_rst_i;
    assign cmd_done    = (state_q == DONE);
    assign wb_cyc_o    = in_burst;
    assign wb_stb_o    = stb;
    assign wb_we_o     = in_burst & we_q;
    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = (in_burst & we_q) ? wdata : '0;
    assign wb_sel_o    = WB_SEL_ALL;
    assign wb_cti_o    = !in_burst ? CTI_CLASSIC : ((beats_q == 8'd1) ? CTI_END : CTI_INCR);
    assign wdata_ready = ack_hit & we_q;
    assign fifo_push   = ack_hit & ~we_q;

    xact_sync_fifo #(
        .W     (DW),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (fifo_push),
        .data_i  (wb_dat_i),
        .pop_i   (rdata_ready),
        .data_o  (rdata),
        .valid_o (rdata_valid),
        .count_o (fifo_count)
    );

endmodule
`default_nettype wire
